score_display_sequencer: RTL and testbench

SCORE_DISPLAY_SEQUENCER -- requirements
Module: score_display_sequencer

---
 rtl/score_display_sequencer.sv | 91 +++++++++
 tb/tb_score_display_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/score_display_sequencer.sv
// score_display_sequencer: rotates BCD player scores onto a two-digit display with a blank gap between players.
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit while a score is shown.
module score_display_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int DWELL_MS    = 3000,
  parameter int BLANK_MS    = 200
) (
  input  logic                     clk_1khz,
  input  logic                     rst_i,
  input  logic [8*NUM_PLAYERS-1:0] scores_i,
  input  logic                     hold_i,
  input  logic                     next_i,
  output logic [3:0]               tens_o,
  output logic [3:0]               ones_o,
  output logic [2:0]               player_o,
  output logic                     blank_o
);
  localparam int MAXC = (DWELL_MS > BLANK_MS) ? DWELL_MS : BLANK_MS;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL_MS - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_MS - 1);
  localparam logic [2:0] LAST = 3'(NUM_PLAYERS - 1);
  localparam bit HAS_GAP = BLANK_MS > 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  typedef enum logic {SHOW, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] plr_q, plr_d, nxt_plr;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic [2:0] player_q;
  logic blank_q, blank_d;
  logic [7:0] sel;
  logic show_done, gap_done;
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      state_q  <= SHOW;
      cnt_q    <= '0;
      plr_q    <= '0;
      tens_q   <= 4'hF;
      ones_q   <= 4'hF;
      blank_q  <= 1'b1;
      player_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      plr_q    <= plr_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      blank_q  <= blank_d;
      player_q <= plr_q;
    end
  end
  always_comb begin
    nxt_plr   = (plr_q == LAST) ? 3'd0 : plr_q + 3'd1;
    show_done = next_i | (~hold_i & (cnt_q == DW_LAST));
    gap_done  = next_i | (cnt_q == BL_LAST);
    state_d   = state_q;
    cnt_d     = cnt_q;
    plr_d     = plr_q;
    if (state_q == SHOW) begin
      if (show_done) begin
        state_d = HAS_GAP ? GAP : SHOW;
        plr_d   = HAS_GAP ? plr_q : nxt_plr;
        cnt_d   = '0;
      end else if (!hold_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = gap_done ? SHOW : GAP;
      plr_d   = gap_done ? nxt_plr : plr_q;
      cnt_d   = gap_done ? '0 : cnt_q + 1'b1;
    end
  end
  // Digits reflect the state held during the cycle, so scores appear one edge after they are sampled.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_PLAYERS; k++)
      if (plr_q == 3'(k)) sel = scores_i[8*k +: 8];
    blank_d = (state_q == GAP);
    tens_d  = blank_d ? 4'hF : (sel[7:4] > 4'd9) ? 4'hE : (LZB && sel[7:4] == 4'd0) ? 4'hF : sel[7:4];
    ones_d  = blank_d ? 4'hF : (sel[3:0] > 4'd9) ? 4'hE : sel[3:0];
  end
  assign tens_o   = tens_q;
  assign ones_o   = ones_q;
  assign player_o = player_q;
  assign blank_o  = blank_q;
endmodule

// File: tb/tb_score_display_sequencer.sv
// tb_score_display_sequencer: directed and random stimulus checked against a countdown-based display model.
module tb_score_display_sequencer;
  localparam int NP = 3, DW = 4, BL = 2;
  logic clk_1khz = 0;
  logic rst_i = 1, hold_i = 0, next_i = 0;
  logic [8*NP-1:0] scores_i = 24'h990712;
  logic [3:0] tens_o, ones_o;
  logic [2:0] player_o;
  logic blank_o;
  int checks = 0, errors = 0;
  bit m_gap;
  int m_player, m_left;
  logic [3:0] e_t, e_o;
  logic [2:0] e_p;
  logic e_b;
  score_display_sequencer #(.NUM_PLAYERS(NP), .DWELL_MS(DW), .BLANK_MS(BL)) dut (
    .clk_1khz(clk_1khz), .rst_i(rst_i), .scores_i(scores_i), .hold_i(hold_i), .next_i(next_i),
    .tens_o(tens_o), .ones_o(ones_o), .player_o(player_o), .blank_o(blank_o));
  always #5 clk_1khz = ~clk_1khz;
  function automatic logic [3:0] disp(input logic [3:0] d, input bit is_tens);
    if (d > 9) return 4'hE;
`ifdef LEADING_ZERO_BLANK_EN
    if (is_tens && d == 0) return 4'hF;
`endif
    return d;
  endfunction
  task automatic leave_player();
    if (BL > 0) begin
      m_gap = 1; m_left = BL;
    end else begin
      m_player = (m_player + 1) % NP; m_left = DW;
    end
  endtask
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask
  // Apply inputs for one cycle, predict what the display shows after the edge, then compare.
  task automatic step(input logic r, input logic h, input logic n);
    rst_i = r; hold_i = h; next_i = n;
    if (r) begin
      e_t = 4'hF; e_o = 4'hF; e_p = 0; e_b = 1;
      m_gap = 0; m_player = 0; m_left = DW;
    end else begin
      logic [7:0] s;
      s = scores_i[8*m_player +: 8];
      e_p = 3'(m_player); e_b = m_gap;
      e_t = m_gap ? 4'hF : disp(s[7:4], 1);
      e_o = m_gap ? 4'hF : disp(s[3:0], 0);
      if (m_gap) begin
        if (n || m_left == 1) begin
          m_gap = 0; m_player = (m_player + 1) % NP; m_left = DW;
        end else m_left--;
      end else if (n || (!h && m_left == 1)) leave_player();
      else if (!h) m_left--;
    end
    @(posedge clk_1khz);
    #1;
    check("tens", tens_o, e_t);
    check("ones", ones_o, e_o);
    check("player", {1'b0, player_o}, {1'b0, e_p});
    check("blank", {3'b0, blank_o}, {3'b0, e_b});
  endtask
  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("first_ones", ones_o, 4'h2);
    check("first_player", {1'b0, player_o}, 4'h0);
    repeat (3) step(0, 0, 0);
    step(0, 0, 0);
    check("gap_blank", {3'b0, blank_o}, 4'h1);
    repeat (3 * 18) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (10) step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);
    repeat (4) step(0, 1, 0);
    step(0, 0, 1);
    scores_i[11:8] = 4'hB;
    repeat (12) step(0, 0, 0);
    while (m_gap || m_player != 0) step(0, 0, 0);
    step(0, 0, 0);
    scores_i[7:0] = 8'h34;
    repeat (4) step(0, 0, 0);
    scores_i[7:0] = 8'h12;
    while (!(m_gap && m_player == 1)) step(0, 0, 0);
    step(1, 1, 1);
    repeat (5) step(0, 0, 0);
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) scores_i[8*$urandom_range(0, NP-1) +: 8] = 8'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
